lib_mul_iter_var: RTL and testbench

LIB_MUL_ITER_VAR -- requirements
Module: lib_mul_iter_var

---
 rtl/lib_mul_iter_var.sv | 126 ++++++++++++
 tb/tb_lib_mul_iter_var.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/lib_mul_iter_var.sv
// lib_mul_iter_var: iterative shift-and-add multiplier, one multiplier bit per cycle.
// Signed operands are reduced to magnitudes and a negate flag, which is applied
// to the product on the last calculation cycle.
// Optional feature: define LIB_MUL_EARLY_TERM_EN to end the calculation as soon
// as the remaining multiplier bits are all zero. Results are identical; only
// latency changes.
module lib_mul_iter_var #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     req_in0,
    input  logic [WIDTH-1:0]     req_in1,
    input  logic                 req_sign,
    input  logic                 req_val,
    output logic                 req_rdy,
    output logic [2*WIDTH-1:0]   rsp_out,
    output logic                 rsp_val,
    input  logic                 rsp_rdy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_sum;
    logic [CW-1:0]      cnt;
    logic               negate;
    logic               calc_last;
    logic [WIDTH-1:0]   mag0;
    logic [WIDTH-1:0]   mag1;

    // Operand magnitudes; the most negative value maps onto itself, which is
    // the correct unsigned magnitude.
    always_comb begin
        mag0 = (req_sign && req_in0[WIDTH-1]) ? (~req_in0 + 1'b1) : req_in0;
        mag1 = (req_sign && req_in1[WIDTH-1]) ? (~req_in1 + 1'b1) : req_in1;
    end

    // Accumulator value after processing the current multiplier LSB.
    always_comb begin
        acc_sum = mplier[0] ? (acc + mcand) : acc;
    end

    // Decide whether the current calculation cycle is the final one.
    always_comb begin
`ifdef LIB_MUL_EARLY_TERM_EN
        calc_last = (mplier[WIDTH-1:1] == '0) || (cnt == CW'(WIDTH - 1));
`else
        calc_last = (cnt == CW'(WIDTH - 1));
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_val)   state_next = CALC;
            CALC:    if (calc_last) state_next = DONE;
            DONE:    if (rsp_rdy)   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latch operands on acceptance, shift-and-add while calculating,
    // and fold in the sign correction on the final step.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            negate <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_val) begin
                        mcand  <= {{WIDTH{1'b0}}, mag0};
                        mplier <= mag1;
                        acc    <= '0;
                        cnt    <= '0;
                        negate <= req_sign & (req_in0[WIDTH-1] ^ req_in1[WIDTH-1]);
                    end
                end
                CALC: begin
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (calc_last && negate) begin
                        acc <= ~acc_sum + 1'b1;
                    end else begin
                        acc <= acc_sum;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs: handshake flags from the state, product only while valid.
    always_comb begin
        req_rdy = (state == IDLE);
        rsp_val = (state == DONE);
        rsp_out = (state == DONE) ? acc : '0;
    end

endmodule

// File: tb/tb_lib_mul_iter_var.sv
// tb_lib_mul_iter_var: directed vectors with a scoreboard queue of expected
// products and latencies, checked by an independent monitor process.
module tb_lib_mul_iter_var;

    localparam int W = 32;

    typedef struct {
        logic [2*W-1:0] prod;
        int             lat;
    } exp_t;

    logic             clk;
    logic             reset;
    logic [W-1:0]     req_in0;
    logic [W-1:0]     req_in1;
    logic             req_sign;
    logic             req_val;
    logic             req_rdy;
    logic [2*W-1:0]   rsp_out;
    logic             rsp_val;
    logic             rsp_rdy;

    exp_t q[$];
    int   checks;
    int   errors;
    int   cyc;
    int   accCyc;
    bit   seen;

    lib_mul_iter_var #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .req_in0  (req_in0),
        .req_in1  (req_in1),
        .req_sign (req_sign),
        .req_val  (req_val),
        .req_rdy  (req_rdy),
        .rsp_out  (rsp_out),
        .rsp_val  (rsp_val),
        .rsp_rdy  (rsp_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Cycles from handshake to first rsp_val: calculation length plus one.
    function automatic int expLatency(input logic [W-1:0] b, input logic s);
        int len;
`ifdef LIB_MUL_EARLY_TERM_EN
        logic [W-1:0] m;
        m = (s && b[W-1]) ? (~b + 1'b1) : b;
        len = 1;
        for (int i = 0; i < W; i++) if (m[i]) len = i + 1;
`else
        len = W + 0 * int'(b[0] ^ s);
`endif
        return len + 1;
    endfunction

    // Monitor: every response cycle is compared against the queue head.
    always @(negedge clk) begin
        if (!reset && cyc > 0) begin
            if (req_val && req_rdy) accCyc = cyc;
            if (rsp_val) begin
                if (q.size() == 0) begin
                    checkOutput("unexpected_rsp", {{(2*W-1){1'b0}}, rsp_val}, '0);
                end else begin
                    checkOutput("rsp_out", rsp_out, q[0].prod);
                    checkOutput("req_rdy_in_done", {{(2*W-1){1'b0}}, req_rdy}, '0);
                    if (!seen) begin
                        checkOutput("latency", 64'(cyc - accCyc), 64'(q[0].lat));
                        seen = 1'b1;
                    end
                    if (rsp_rdy) begin
                        void'(q.pop_front());
                        seen = 1'b0;
                    end
                end
            end else begin
                checkOutput("rsp_out_zero", rsp_out, '0);
            end
        end
    end

    task automatic waitReady();
        int n;
        n = 0;
        while (!req_rdy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_rdy) checkOutput("req_rdy_timeout", {{(2*W-1){1'b0}}, req_rdy}, 64'd1);
    endtask

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                 input logic [2*W-1:0] exp, input int hold);
        int n;
        waitReady();
        req_in0  = a;
        req_in1  = b;
        req_sign = s;
        req_val  = 1'b1;
        q.push_back('{prod: exp, lat: expLatency(b, s)});
        @(posedge clk); #1;
        req_val  = 1'b0;
        req_in0  = $urandom;
        req_in1  = $urandom;
        req_sign = ~s;
        n = 0;
        while (!rsp_val && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!rsp_val) begin
            checkOutput("rsp_val_timeout", {{(2*W-1){1'b0}}, rsp_val}, 64'd1);
            if (q.size() > 0) void'(q.pop_front());
            seen = 1'b0;
            return;
        end
        repeat (hold) begin
            @(posedge clk); #1;
        end
        rsp_rdy = 1'b1;
        @(posedge clk); #1;
        rsp_rdy = 1'b0;
        checkOutput("idle_after_rsp", {{(2*W-1){1'b0}}, req_rdy}, 64'd1);
        checkOutput("rsp_val_cleared", {{(2*W-1){1'b0}}, rsp_val}, '0);
    endtask

    // Reset during CALC: the request is abandoned and never answered.
    task automatic resetInCalc();
        waitReady();
        req_in0  = 32'd3;
        req_in1  = 32'd5;
        req_sign = 1'b0;
        req_val  = 1'b1;
        @(posedge clk); #1;
        req_val = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("rst_req_rdy", {{(2*W-1){1'b0}}, req_rdy}, 64'd1);
        checkOutput("rst_rsp_val", {{(2*W-1){1'b0}}, rsp_val}, '0);
        checkOutput("rst_rsp_out", rsp_out, '0);
        repeat (60) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        cyc      = 0;
        accCyc   = 0;
        seen     = 1'b0;
        reset    = 1'b1;
        req_in0  = '0;
        req_in1  = '0;
        req_sign = 1'b0;
        req_val  = 1'b0;
        rsp_rdy  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_req_rdy", {{(2*W-1){1'b0}}, req_rdy}, 64'd1);
        checkOutput("reset_rsp_val", {{(2*W-1){1'b0}}, rsp_val}, '0);
        checkOutput("reset_rsp_out", rsp_out, '0);
        reset = 1'b0;
        @(posedge clk); #1;

        applyStimulus(32'd3,          32'd5,          1'b0, 64'h0000_0000_0000_000F, 0);
        applyStimulus(32'hFFFF_FFFD,  32'd5,          1'b1, 64'hFFFF_FFFF_FFFF_FFF1, 0);
        applyStimulus(32'h8000_0000,  32'h8000_0000,  1'b1, 64'h4000_0000_0000_0000, 0);
        applyStimulus(32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 64'hFFFF_FFFE_0000_0001, 10);
        applyStimulus(32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 64'h0000_0000_0000_0001, 0);
        applyStimulus(32'd7,          32'd2,          1'b0, 64'd14, 2);
        applyStimulus(32'd7,          32'd0,          1'b0, 64'd0, 0);
        applyStimulus(32'd7,          32'hFFFF_FFFE,  1'b1, 64'hFFFF_FFFF_FFFF_FFF2, 0);
        applyStimulus(32'h8000_0000,  32'd2,          1'b0, 64'h0000_0001_0000_0000, 0);
        applyStimulus(32'h8000_0000,  32'd1,          1'b1, 64'hFFFF_FFFF_8000_0000, 0);

        resetInCalc();

        applyStimulus(32'd12345,      32'd1000,       1'b0, 64'd12345000, 1);

        repeat (5) @(posedge clk);
        #1;
        checkOutput("queue_drained", 64'(q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
